// File: rtl/return_addr_stack.sv
// Return-address stack: circular LIFO of call return addresses.
// Ports: clk, rst (async low), push/pop/address/err_clr in;
// stack_out/stack_valid, count/empty/full, overflow/underflow out.
// Macro RAS_STICKY_ERR_EN: sticky error flags cleared by err_clr.
module return_addr_stack #(
  parameter int DEPTH    = 8,
  parameter int ADDR_LEN = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_LEN-1:0]        address,
  input  logic                       err_clr,
  output logic [ADDR_LEN-1:0]        stack_out,
  output logic                       stack_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ACTIVE,
    S_FULL
  } state_t;

  state_t              state;
  logic [PW-1:0]       top;
  logic [PW-1:0]       top_inc;
  logic [PW-1:0]       top_dec;
  logic [ADDR_LEN-1:0] mem [DEPTH];
  logic                ovf_evt;
  logic                unf_evt;

  always_comb begin
    state = S_ACTIVE;
    unique case (1'b1)
      (count == CW'(0)):     state = S_EMPTY;
      (count == CW'(DEPTH)): state = S_FULL;
      default:               state = S_ACTIVE;
    endcase
  end

  assign empty   = (state == S_EMPTY);
  assign full    = (state == S_FULL);
  assign top_inc = top + PW'(1);
  assign top_dec = top - PW'(1);
  assign ovf_evt = push & ~pop & full;
  assign unf_evt = pop & ~push & empty;

  // Storage is not reset; writes are blocked while rst is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (push && !pop)
        mem[top_inc] <= address;
      else if (push && pop && !empty)
        mem[top] <= address;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      top         <= '0;
      stack_out   <= '0;
      stack_valid <= 1'b0;
    end else begin
      stack_valid <= 1'b0;
      unique case ({push, pop})
        2'b10: begin
          // When full, top+1 is the oldest slot and gets overwritten.
          top <= top_inc;
          if (!full) count <= count + CW'(1);
        end
        2'b01: begin
          if (!empty) begin
            stack_out   <= mem[top];
            top         <= top_dec;
            count       <= count - CW'(1);
            stack_valid <= 1'b1;
          end
        end
        2'b11: begin
          stack_out   <= empty ? address : mem[top];
          stack_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RAS_STICKY_ERR_EN
  // A new error wins over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow & ~err_clr);
      underflow <= unf_evt | (underflow & ~err_clr);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt;
      underflow <= unf_evt;
    end
  end
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: queue model + directed cases.
// Follows RAS_STICKY_ERR_EN the same way as the design build.
module tb_return_addr_stack;

  localparam int DEPTH = 8;
  localparam int AL    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AL-1:0] address = '0;
  logic          err_clr = 1'b0;
  logic [AL-1:0] stack_out;
  logic          stack_valid;
  logic [3:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  return_addr_stack #(.DEPTH(DEPTH), .ADDR_LEN(AL)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .address(address), .err_clr(err_clr),
    .stack_out(stack_out), .stack_valid(stack_valid),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [AL-1:0] mq[$];
  logic [AL-1:0] m_out = '0;
  bit            m_valid = 1'b0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  task automatic chk(string n, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out   = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step(bit p, bit o, logic [AL-1:0] a, bit c);
    bit ov = 1'b0;
    bit un = 1'b0;
    m_valid = 1'b0;
    if (p && !o) begin
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front());
        ov = 1'b1;
      end
      mq.push_back(a);
    end else if (o && !p) begin
      if (mq.size() > 0) begin
        m_out   = mq.pop_back();
        m_valid = 1'b1;
      end else begin
        un = 1'b1;
      end
    end else if (p && o) begin
      if (mq.size() > 0) begin
        m_out = mq[mq.size()-1];
        mq[mq.size()-1] = a;
      end else begin
        m_out = a;
      end
      m_valid = 1'b1;
    end
`ifdef RAS_STICKY_ERR_EN
    m_ovf = ov | (m_ovf & ~c);
    m_unf = un | (m_unf & ~c);
`else
    m_ovf = ov;
    m_unf = un;
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(count), mq.size());
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("stack_out", int'(stack_out), int'(m_out));
      chk("stack_valid", int'(stack_valid), int'(m_valid));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
    end
  end

  task automatic step(bit p, bit o, logic [AL-1:0] a, bit c);
    push = p;
    pop = o;
    address = a;
    err_clr = c;
    @(posedge clk);
    model_step(p, o, a, c);
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);

    // LIFO order
    step(1, 0, 12'h010, 0);
    step(1, 0, 12'h020, 0);
    step(1, 0, 12'h030, 0);
    chk("r30_cnt3", int'(count), 3);
    step(0, 1, 0, 0);
    chk("r30_pop1", int'(stack_out), 'h030);
    chk("r30_v1", int'(stack_valid), 1);
    step(0, 1, 0, 0);
    chk("r30_pop2", int'(stack_out), 'h020);
    step(0, 1, 0, 0);
    chk("r30_pop3", int'(stack_out), 'h010);
    chk("r30_v3", int'(stack_valid), 1);
    chk("r30_empty", int'(empty), 1);

    // overflow wraps, underflow holds stack_out
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(1, 0, AL'(i), 0);
      if (i == 8) chk("r31_full", int'(full), 1);
    end
    chk("r31_ovf", int'(overflow), 1);
    chk("r31_cnt", int'(count), 8);
    for (int i = 9; i >= 2; i--) begin
      step(0, 1, 0, 0);
      chk("r31_pop", int'(stack_out), i);
    end
    step(0, 1, 0, 0);
    chk("r31_unf", int'(underflow), 1);
    chk("r31_hold", int'(stack_out), 'h002);
    chk("r31_nv", int'(stack_valid), 0);

    // simultaneous push/pop replaces top
    do_reset();
    step(1, 0, 12'h055, 0);
    step(1, 0, 12'h0AB, 0);
    step(1, 1, 12'h0CD, 0);
    chk("r32_out", int'(stack_out), 'h0AB);
    chk("r32_cnt", int'(count), 2);
    step(0, 1, 0, 0);
    chk("r32_next", int'(stack_out), 'h0CD);

    // empty bypass
    do_reset();
    step(1, 1, 12'h123, 0);
    chk("r33_out", int'(stack_out), 'h123);
    chk("r33_v", int'(stack_valid), 1);
    chk("r33_cnt", int'(count), 0);
    chk("r33_unf", int'(underflow), 0);

    // mid-cycle reset with a push pending
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, AL'(12'h200 + i), 0);
    chk("r34_cnt5", int'(count), 5);
    chk_en = 1'b0;
    push = 1'b1;
    address = 12'h3FF;
    #2 rst = 1'b0;
    #1;
    chk("r34_cnt0", int'(count), 0);
    chk("r34_out0", int'(stack_out), 0);
    chk("r34_v0", int'(stack_valid), 0);
    chk("r34_ovf0", int'(overflow), 0);
    chk("r34_unf0", int'(underflow), 0);
    chk("r34_empty", int'(empty), 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
    rst = 1'b1;
    chk_en = 1'b1;
    step(0, 1, 0, 0);
    chk("r34_unf", int'(underflow), 1);
    chk("r34_nv", int'(stack_valid), 0);

    // error flag lifetime
    do_reset();
    step(0, 1, 0, 0);
    chk("r35_unf", int'(underflow), 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
`ifdef RAS_STICKY_ERR_EN
      chk("r35_stick", int'(underflow), 1);
`else
      chk("r35_pulse", int'(underflow), 0);
`endif
    end
    step(0, 0, 0, 1);
    chk("r35_clr", int'(underflow), 0);
    step(0, 1, 0, 1);
    chk("r35_clr_new", int'(underflow), 1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           AL'($urandom), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of return-address entries (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_LEN, default 12, meaning width of a stored address.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port push, input, 1 bit: store address on top.
REQ-006 SHALL have port pop, input, 1 bit: remove the top entry and present it on stack_out.
REQ-007 SHALL have port address, input, ADDR_LEN bits: return address to push (PC+1 from decode).
REQ-008 SHALL have port err_clr, input, 1 bit: clears the error flags.
REQ-009 SHALL have port stack_out, output, ADDR_LEN bits: registered popped address.
REQ-010 SHALL have port stack_valid, output, 1 bit: stack_out was loaded by the previous cycle's pop.
REQ-011 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have ports empty and full, output, 1 bit each: count==0 and count==DEPTH.
REQ-013 SHALL have ports overflow and underflow, output, 1 bit each: error indications.

Function
REQ-014 SHALL store entries in a circular buffer indexed by a log2(DEPTH)-bit top pointer that wraps modulo DEPTH.
REQ-015 SHALL implement an FSM with states EMPTY (count 0), ACTIVE (0<count<DEPTH) and FULL (count DEPTH), each derived from count.
REQ-016 SHALL, on push only, write address at top+1, advance top and increment count, with one edge of latency.
REQ-017 SHALL, on push only in FULL, overwrite the oldest entry, hold count at DEPTH and flag overflow.
REQ-018 SHALL, on pop only in ACTIVE or FULL, load stack_out with the top entry, retreat top, decrement count and set stack_valid=1 for one cycle.
REQ-019 SHALL, on pop only in EMPTY, hold stack_out, set stack_valid=0, leave count at 0 and flag underflow.
REQ-020 SHALL, on simultaneous push and pop when not EMPTY, load stack_out with the old top, replace the top entry with address, and leave count and top unchanged.
REQ-021 SHALL, on simultaneous push and pop in EMPTY, bypass: stack_out=address, stack_valid=1, count stays 0, no underflow.
REQ-022 SHALL hold all state when neither push nor pop is asserted, with stack_valid=0.
REQ-023 SHALL drive empty, full and count combinationally from registered state only, never from push or pop.

Reset
REQ-024 SHALL, while rst=0, asynchronously clear count, top, stack_out, stack_valid, overflow and underflow to 0.
REQ-025 SHALL come out of reset in EMPTY with empty=1 and full=0.
REQ-026 SHALL not require the entry storage to be cleared by reset.
REQ-027 SHALL abandon any push or pop in progress when reset is asserted mid-operation, with no partial update after release.

Configuration
REQ-028 SHALL, with macro RAS_STICKY_ERR_EN defined, hold overflow and underflow high once set until err_clr is sampled high; err_clr coinciding with a new error leaves the flag set.
REQ-029 SHALL, without RAS_STICKY_ERR_EN, pulse overflow and underflow for exactly one cycle per error and ignore err_clr.

Verification
REQ-030 SHALL cover: reset, then push 0x010, 0x020, 0x030, then 3 pops -> stack_out 0x030, 0x020, 0x010, each with stack_valid=1; count 3->0; empty=1.
REQ-031 SHALL cover: DEPTH=8, push 0x001..0x009 -> full=1, overflow set on 9th push; 8 pops return 0x009..0x002; 9th pop gives underflow, stack_out stays 0x002.
REQ-032 SHALL cover: count=2 with top 0x0AB, push 0x0CD and pop together -> stack_out=0x0AB, count=2; next pop -> 0x0CD.
REQ-033 SHALL cover: EMPTY, push 0x123 and pop together -> stack_out=0x123, stack_valid=1, count=0, underflow=0.
REQ-034 SHALL cover: count=5, assert rst low mid-cycle -> all outputs 0 immediately; after release, pop -> underflow, stack_valid=0.
REQ-035 SHALL cover: pop in EMPTY with RAS_STICKY_ERR_EN -> underflow stays 1 for 10 cycles until err_clr=1, then 0; without the macro -> a 1-cycle pulse only.
